fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage plus IF/ID boundary of the 5-stage MIPS core. Directly upstream of the ID-stage main decoder.
- Owns the PC register and drives the synchronous instruction SRAM (1-cycle read latency).
- Presents `instrD`, `pcD` and the link address to ID. Holds them under `stallD`; flushes them to NOP under `flushD`.
- Applies branch/jump redirects resolved in ID, with MIPS delay-slot semantics.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0000, instruction word presented to ID when D is invalid or flushed.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- stallF  in  1  hold the PC.
- stallD  in  1  hold the IF/ID contents.
- flushD  in  1  invalidate the IF/ID contents at the next edge.
- branch_takenD  in  1  conditional branch in ID has resolved taken.
- jumpD  in  1  J or JAL in ID.
- jrD  in  1  JR or JALR in ID.
- rs_valueD  in  32  forwarded rs value; this is the JR/JALR target.
- inst_sram_en  out  1  SRAM read enable.
- inst_sram_addr  out  32  SRAM read address.
- inst_sram_rdata  in  32  SRAM data for the address presented in the previous cycle.
- pcF  out  32  current fetch PC.
- pcD  out  32  PC of the instruction in ID.
- pc_plus8D  out  32  link address for JAL, JALR, BLTZAL and BGEZAL.
- instrD  out  32  instruction in ID.
- validD  out  1  ID holds a real instruction.

Behaviour:
- Reset (rst=0, asynchronous):
  - pcF=RESET_PC; pcD=0; validD=0; hold_valid=0; hold_instr=0; inst_sram_en=0.
  - instrD=NOP_INSTR while validD=0.
- SRAM interface:
  - inst_sram_en = rst.
  - inst_sram_addr = pcF (combinational).
  - Data for address A appears on rdata in the cycle after A was presented.
- Next PC:
  - pc_plus4D = pcD+4.
  - Jump target = {pc_plus4D[31:28], instrD[25:0], 2'b00}.
  - Branch target = pc_plus4D + (sign-extended instrD[15:0] << 2), mod 2^32.
  - Redirects are honoured only when validD=1 and stallD=0.
  - Priority: jrD -> rs_valueD; else jumpD -> jump target; else branch_takenD -> branch target; else pcF+4.
  - PC arithmetic wraps mod 2^32. Misaligned targets are passed through unchanged.
- PC register:
  - If stallF=1, pcF holds.
  - Else pcF <= next PC.
  - The instruction already in F when a redirect occurs is the delay slot. It is never squashed by this block.
- IF/ID register, first matching rule wins:
  1. flushD=1 (has priority over stallD): validD<=0, hold_valid<=0; pcD holds its value.
  2. stallD=1: pcD and validD hold. If hold_valid=0, then hold_instr<=instrD (the current combinational value) and hold_valid<=1. Later stall cycles keep the first capture.
  3. Otherwise: pcD<=pcF; validD<=~stallF; hold_valid<=0.
  - A bubble enters ID when F is stalled but D is not.
- instrD mux (combinational):
  - validD=0 -> NOP_INSTR.
  - Else hold_valid=1 -> hold_instr.
  - Else -> inst_sram_rdata.
- pc_plus8D = pcD+8.
- Latency: a PC takes 1 cycle from presentation on inst_sram_addr to appearing on pcD/instrD, when unstalled.
- Boundaries:
  - First cycle after reset release: validD=0. The second cycle shows RESET_PC in ID.
  - stallD and flushD together: the flush wins.
  - Multi-cycle stall: instrD stays stable every cycle of the stall.
  - Reset mid-stall: everything returns to reset values immediately.

Decomposition:
- Shared package/defines header: RESET_PC, NOP_INSTR, and the 32-bit width constant.
- One natural sub-module, `pc_next_sel`: combinational target computation and priority mux.
- The PC register, IF/ID register and hold buffer stay in `fetch_stage`.

Test Plan:
- Reset release, no stalls -> pcF steps BFC00000, BFC00004, BFC00008, ... Cycle 1 validD=0; cycle 2 pcD=BFC00000 with instrD equal to the SRAM word there.
- instrD=0x10000003 (BEQ, imm=3) at pcD=BFC00010 with branch_takenD=1 -> pcF goes BFC00014 (delay slot) then BFC00020; pc_plus8D=BFC00018.
- jrD=1, rs_valueD=0x8000_1234, jumpD=1 in the same cycle -> the next pcF is 0x8000_1234 (JR priority).
- stallF=stallD=1 for 3 cycles while pcD=BFC00008 -> pcD, instrD and validD are constant for all 3 cycles. On release, pcD advances to BFC0000C with the correct word.
- flushD=1 together with stallD=1 -> next cycle validD=0 and instrD=0x00000000.
- rst pulsed low mid-stall -> pcF=BFC00000, validD=0 and inst_sram_en=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types, constants and target helpers for the IF stage.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_PC_DEF  = 32'hBFC0_0000;
  localparam word_t NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_JR
  } pc_sel_e;

  // J/JAL: keep the 256 MB region of the delay slot, splice in the index
  function automatic word_t jump_target(input logic [3:0] pc_hi, input logic [25:0] idx);
    return {pc_hi, idx, 2'b00};
  endfunction

  function automatic word_t branch_target(input word_t pc_plus4, input logic [15:0] imm);
    return pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction SRAM read port: fetch side is master, memory side is slave.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic  inst_sram_en;
  word_t inst_sram_addr;
  word_t inst_sram_rdata;

  modport master (
    output inst_sram_en,
    output inst_sram_addr,
    input  inst_sram_rdata
  );

  modport slave (
    input  inst_sram_en,
    input  inst_sram_addr,
    output inst_sram_rdata
  );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC selection: redirect target computation and jr > jump > branch > sequential priority.
module pc_next_sel
  import fetch_stage_pkg::*;
(
  input  word_t       pcF,
  input  word_t       pc_plus4D,
  input  logic [25:0] instr_idx,
  input  logic        redirect_en,
  input  logic        jrD,
  input  logic        jumpD,
  input  logic        branch_takenD,
  input  word_t       rs_valueD,
  output word_t       pc_next_c
);

  pc_sel_e sel_c;

  // Redirects only count for a real, advancing instruction in ID
  always_comb begin
    sel_c = SEL_SEQ;
    if (redirect_en) begin
      if (jrD)                sel_c = SEL_JR;
      else if (jumpD)         sel_c = SEL_JUMP;
      else if (branch_takenD) sel_c = SEL_BRANCH;
    end
  end

  always_comb begin
    pc_next_c = pcF + 32'd4;
    case (sel_c)
      SEL_JR:     pc_next_c = rs_valueD;
      SEL_JUMP:   pc_next_c = jump_target(pc_plus4D[31:28], instr_idx);
      SEL_BRANCH: pc_next_c = branch_target(pc_plus4D, instr_idx[15:0]);
      default:    pc_next_c = pcF + 32'd4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID boundary: PC register, SRAM fetch, stall hold buffer and flush.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC  = RESET_PC_DEF,
  parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master sram,
  input  logic          stallF,
  input  logic          stallD,
  input  logic          flushD,
  input  logic          branch_takenD,
  input  logic          jumpD,
  input  logic          jrD,
  input  word_t         rs_valueD,
  output word_t         pcF,
  output word_t         pcD,
  output word_t         pc_plus8D,
  output word_t         instrD,
  output logic          validD
);

  logic  hold_valid;
  word_t hold_instr;
  word_t pc_plus4D;
  word_t pc_next_c;
  logic  redirect_en;

  assign sram.inst_sram_en   = rst;
  assign sram.inst_sram_addr = pcF;

  assign pc_plus4D   = pcD + 32'd4;
  assign pc_plus8D   = pcD + 32'd8;
  assign redirect_en = validD & ~stallD;

  pc_next_sel u_pc_next_sel (
    .pcF           (pcF),
    .pc_plus4D     (pc_plus4D),
    .instr_idx     (instrD[25:0]),
    .redirect_en   (redirect_en),
    .jrD           (jrD),
    .jumpD         (jumpD),
    .branch_takenD (branch_takenD),
    .rs_valueD     (rs_valueD),
    .pc_next_c     (pc_next_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcF <= RESET_PC;
    end else if (!stallF) begin
      pcF <= pc_next_c;
    end
  end

  // The SRAM word only lives one cycle, so the first stall cycle latches it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcD        <= '0;
      validD     <= 1'b0;
      hold_valid <= 1'b0;
      hold_instr <= '0;
    end else if (flushD) begin
      validD     <= 1'b0;
      hold_valid <= 1'b0;
    end else if (stallD) begin
      if (!hold_valid) begin
        hold_instr <= instrD;
        hold_valid <= 1'b1;
      end
    end else begin
      pcD        <= pcF;
      validD     <= ~stallF;
      hold_valid <= 1'b0;
    end
  end

  always_comb begin
    instrD = sram.inst_sram_rdata;
    if (!validD)        instrD = NOP_INSTR;
    else if (hold_valid) instrD = hold_instr;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed check of fetch_stage against an instruction-level model of F and D.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam word_t T_RESET_PC = 32'hBFC0_0000;
  localparam word_t T_NOP      = 32'h0000_0000;

  logic  clk, rst;
  logic  stallF, stallD, flushD, branch_takenD, jumpD, jrD;
  word_t rs_valueD, pcF, pcD, pc_plus8D, instrD;
  logic  validD;

  int n_total = 0;
  int n_bad   = 0;

  word_t m_pcF, m_pcD;
  logic  m_valid;

  fetch_stage_if sram_if ();

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .sram          (sram_if),
    .stallF        (stallF),
    .stallD        (stallD),
    .flushD        (flushD),
    .branch_takenD (branch_takenD),
    .jumpD         (jumpD),
    .jrD           (jrD),
    .rs_valueD     (rs_valueD),
    .pcF           (pcF),
    .pcD           (pcD),
    .pc_plus8D     (pc_plus8D),
    .instrD        (instrD),
    .validD        (validD)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic word_t mem(input word_t a);
    if (a == 32'hBFC0_0010) return 32'h1000_0003;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  always @(posedge clk) begin
    if (sram_if.inst_sram_en) sram_if.inst_sram_rdata <= mem(sram_if.inst_sram_addr);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic word_t model_instr();
    return m_valid ? mem(m_pcD) : T_NOP;
  endfunction

  task automatic check_all();
    check("pcF", pcF, m_pcF);
    check("sram_addr", sram_if.inst_sram_addr, m_pcF);
    check("sram_en", 32'(sram_if.inst_sram_en), 32'd1);
    check("validD", 32'(validD), 32'(m_valid));
    check("pcD", pcD, m_pcD);
    check("instrD", instrD, model_instr());
    check("pc_plus8D", pc_plus8D, m_pcD + 32'd8);
  endtask

  task automatic model_reset();
    m_pcF   = T_RESET_PC;
    m_pcD   = 32'd0;
    m_valid = 1'b0;
  endtask

  // One cycle: check at negedge, drive controls, predict, cross the edge.
  task automatic step(input logic sf, input logic sd, input logic fd,
                      input logic br, input logic jp, input logic jr, input word_t rs);
    word_t instr_d, pc4, tgt, nx_pcF, nx_pcD;
    logic  nx_valid, redir;
    int    off;
    check_all();
    stallF = sf; stallD = sd; flushD = fd;
    branch_takenD = br; jumpD = jp; jrD = jr; rs_valueD = rs;

    instr_d = model_instr();
    pc4     = m_pcD + 32'd4;
    redir   = m_valid && !sd;
    off     = int'($signed(instr_d[15:0])) * 4;
    if (redir && jr)      tgt = rs;
    else if (redir && jp) tgt = (pc4 & 32'hF000_0000) | ((instr_d & 32'h03FF_FFFF) << 2);
    else if (redir && br) tgt = pc4 + word_t'(off);
    else                  tgt = m_pcF + 32'd4;
    nx_pcF = sf ? m_pcF : tgt;

    nx_pcD = m_pcD; nx_valid = m_valid;
    if (fd) nx_valid = 1'b0;
    else if (!sd) begin
      nx_pcD   = m_pcF;
      nx_valid = !sf;
    end

    @(posedge clk);
    m_pcF = nx_pcF; m_pcD = nx_pcD; m_valid = nx_valid;
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
    branch_takenD = 1'b0; jumpD = 1'b0; jrD = 1'b0; rs_valueD = 32'd0;
    model_reset();
    @(negedge clk);
    check("rst_pcF", pcF, T_RESET_PC);
    check("rst_validD", 32'(validD), 32'd0);
    check("rst_en", 32'(sram_if.inst_sram_en), 32'd0);
    check("rst_pcD", pcD, 32'd0);
    check("rst_instrD", instrD, T_NOP);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    do_reset();

    // Sequential fetch out of reset
    idle_step();
    check("seq_pcD0", pcD, 32'hBFC0_0000);
    check("seq_instr0", instrD, mem(32'hBFC0_0000));
    check("seq_pcF1", pcF, 32'hBFC0_0004);
    check("seq_valid", 32'(validD), 32'd1);
    for (int i = 0; i < 4; i++) idle_step();

    // Taken BEQ with imm=3 at BFC00010
    check("beq_pcD", pcD, 32'hBFC0_0010);
    check("beq_instr", instrD, 32'h1000_0003);
    check("beq_slot_pcF", pcF, 32'hBFC0_0014);
    check("beq_plus8", pc_plus8D, 32'hBFC0_0018);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    check("beq_tgt_pcF", pcF, 32'hBFC0_0020);
    check("beq_slot_pcD", pcD, 32'hBFC0_0014);
    idle_step();
    check("beq_tgt_pcD", pcD, 32'hBFC0_0020);

    // JR wins over J in the same cycle
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_1234);
    check("jr_prio_pcF", pcF, 32'h8000_1234);

    // Three-cycle full stall at pcD=BFC00008
    do_reset();
    for (int i = 0; i < 3; i++) idle_step();
    check("stall_pre_pcD", pcD, 32'hBFC0_0008);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      check("stall_pcD", pcD, 32'hBFC0_0008);
      check("stall_instr", instrD, mem(32'hBFC0_0008));
      check("stall_valid", 32'(validD), 32'd1);
    end
    idle_step();
    check("unstall_pcD", pcD, 32'hBFC0_000C);
    check("unstall_instr", instrD, mem(32'hBFC0_000C));

    // Flush beats stall
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check("flush_valid", 32'(validD), 32'd0);
    check("flush_instr", instrD, T_NOP);

    // Asynchronous reset in the middle of a stall
    idle_step();
    idle_step();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("arst_pcF", pcF, T_RESET_PC);
    check("arst_valid", 32'(validD), 32'd0);
    check("arst_en", 32'(sram_if.inst_sram_en), 32'd0);
    check("arst_instr", instrD, T_NOP);
    model_reset();
    stallF = 1'b0; stallD = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      word_t rs;
      rs = $urandom;
      if ($urandom_range(0, 1) == 0) rs = rs & 32'hFFFF_FFFC;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 7) == 0, rs);
    end
    check_all();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
